// File: rtl/tsu_pkg.sv
// rtl/tsu_pkg.sv - shared types and constants for the TSU queue drain arbiter
//
// Purpose:
//   Holds the drain FSM state encoding, the source identifiers used on
//   out_src and in the round-robin history, the default queue geometry, and
//   the two-way round-robin pick function used by rr_arb2.
// Contents:
//   state_e     IDLE / RD / WAIT / HOLD
//   SRC_RX      source id 0 (RX timestamp queue)
//   SRC_TX      source id 1 (TX timestamp queue)
//   DEF_DATA_W  default queue entry width
//   DEF_STAT_W  default queue entry-count width
//   rr_pick()   grant source for a two-way round-robin decision

package tsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_e;

  localparam logic SRC_RX = 1'b0;
  localparam logic SRC_TX = 1'b1;

  localparam int DEF_DATA_W = 128;
  localparam int DEF_STAT_W = 8;

  // With a single requester it wins outright; with both requesting, the
  // source that did not win last time gets the grant.
  function automatic logic rr_pick(input logic req_rx,
                                   input logic req_tx,
                                   input logic last_src);
    logic pick;
    if (req_rx && req_tx) begin
      pick = ~last_src;
    end else if (req_tx) begin
      pick = SRC_TX;
    end else begin
      pick = SRC_RX;
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin picker for the RX/TX queue drain
//
// Purpose:
//   Combinational grant selection between the RX and TX queues. The caller
//   owns the history bit (last_src_i) and decides when a grant is taken.
// Ports:
//   req_rx_i    RX queue has at least one entry
//   req_tx_i    TX queue has at least one entry
//   last_src_i  source granted on the previous accepted decision
//   gnt_vld_o   at least one request present
//   gnt_src_o   granted source (SRC_RX / SRC_TX); meaningful when gnt_vld_o

module rr_arb2
  import tsu_pkg::*;
(
  input  logic req_rx_i,
  input  logic req_tx_i,
  input  logic last_src_i,
  output logic gnt_vld_o,
  output logic gnt_src_o
);

  assign gnt_vld_o = req_rx_i | req_tx_i;
  assign gnt_src_o = rr_pick(req_rx_i, req_tx_i, last_src_i);

endmodule

// File: rtl/tsu_q_drain_arb.sv
// rtl/tsu_q_drain_arb.sv - drains RX/TX timestamp queues into one output stream
//
// Purpose:
//   Round-robin arbiter that pops one entry at a time from the RX or TX
//   timestamp queue with a single-cycle read strobe, waits the queue read
//   latency, captures the entry and holds it on a valid/ready output until
//   the downstream accepts it. Only one read is ever outstanding.
// Parameters:
//   RD_LAT  cycles from read strobe to valid queue data (1..4)
//   STAT_W  width of the queue entry-count inputs
//   DATA_W  width of a queue entry
// Ports:
//   clk         queue read clock, rising edge
//   rst         asynchronous active-low reset
//   en          drain enable, sampled only when deciding in IDLE
//   rx_q_stat   RX queue entry count
//   rx_q_data   RX queue read data
//   rx_q_rd_en  RX queue read strobe
//   tx_q_stat   TX queue entry count
//   tx_q_data   TX queue read data
//   tx_q_rd_en  TX queue read strobe
//   out_valid   captured entry valid
//   out_ready   downstream accept
//   out_data    captured entry
//   out_src     source of captured entry (0 = RX, 1 = TX)
//   busy        FSM not in IDLE
// Optional feature (macro TSU_Q_DRAIN_CNT_EN):
//   cnt_clr     synchronous clear of both handshake counters
//   rx_cnt      completed RX handshakes, wraps at 16 bits
//   tx_cnt      completed TX handshakes, wraps at 16 bits

module tsu_q_drain_arb
  import tsu_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int STAT_W = DEF_STAT_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [STAT_W-1:0] rx_q_stat,
  input  logic [DATA_W-1:0] rx_q_data,
  output logic              rx_q_rd_en,
  input  logic [STAT_W-1:0] tx_q_stat,
  input  logic [DATA_W-1:0] tx_q_data,
  output logic              tx_q_rd_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  output logic              busy
`ifdef TSU_Q_DRAIN_CNT_EN
  ,
  input  logic              cnt_clr,
  output logic [15:0]       rx_cnt,
  output logic [15:0]       tx_cnt
`endif
);

  // Wide enough for RD_LAT-1 with RD_LAT up to 4.
  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RD_LAT - 1);

  state_e            state_q;
  logic              src_q;
  logic              last_src_q;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic              rx_rd_en_q;
  logic              tx_rd_en_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_src_q;

  logic req_rx;
  logic req_tx;
  logic gnt_vld;
  logic gnt_src;

  assign req_rx = (rx_q_stat != '0);
  assign req_tx = (tx_q_stat != '0);

  rr_arb2 u_rr_arb2 (
    .req_rx_i   (req_rx),
    .req_tx_i   (req_tx),
    .last_src_i (last_src_q),
    .gnt_vld_o  (gnt_vld),
    .gnt_src_o  (gnt_src)
  );

  // Read strobes are set on the edge entering RD and cleared on the edge
  // leaving it, so each strobe is exactly one cycle and matches state RD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      src_q       <= SRC_RX;
      last_src_q  <= SRC_TX;
      wait_cnt_q  <= '0;
      rx_rd_en_q  <= 1'b0;
      tx_rd_en_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= SRC_RX;
    end else begin
      case (state_q)
        IDLE: begin
          if (en && gnt_vld) begin
            src_q      <= gnt_src;
            last_src_q <= gnt_src;
            rx_rd_en_q <= (gnt_src == SRC_RX);
            tx_rd_en_q <= (gnt_src == SRC_TX);
            state_q    <= RD;
          end
        end
        RD: begin
          rx_rd_en_q <= 1'b0;
          tx_rd_en_q <= 1'b0;
          wait_cnt_q <= WAIT_LOAD;
          state_q    <= WAIT;
        end
        WAIT: begin
          // The queue data becomes valid in the WAIT cycle where the count
          // has run down to zero; it is captured on that cycle's edge.
          if (wait_cnt_q == '0) begin
            out_data_q  <= (src_q == SRC_TX) ? tx_q_data : rx_q_data;
            out_src_q   <= src_q;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end else begin
            wait_cnt_q <= wait_cnt_q - 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rx_q_rd_en = rx_rd_en_q;
  assign tx_q_rd_en = tx_rd_en_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_src    = out_src_q;
  assign busy       = (state_q != IDLE);

`ifdef TSU_Q_DRAIN_CNT_EN
  logic        hs;
  logic [15:0] rx_cnt_q;
  logic [15:0] rx_cnt_d;
  logic [15:0] tx_cnt_q;
  logic [15:0] tx_cnt_d;

  // out_src_q is stable throughout HOLD, so it names the handshake source.
  assign hs = out_valid_q & out_ready;

  always_comb begin
    rx_cnt_d = rx_cnt_q;
    tx_cnt_d = tx_cnt_q;
    if (cnt_clr) begin
      rx_cnt_d = '0;
      tx_cnt_d = '0;
    end else if (hs) begin
      if (out_src_q == SRC_TX) begin
        tx_cnt_d = tx_cnt_q + 16'd1;
      end else begin
        rx_cnt_d = rx_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
    end else begin
      rx_cnt_q <= rx_cnt_d;
      tx_cnt_q <= tx_cnt_d;
    end
  end

  assign rx_cnt = rx_cnt_q;
  assign tx_cnt = tx_cnt_q;
`else
  // Handshake counters are not built; the drain path above is unchanged.
`endif

endmodule

// File: tb/tb_tsu_q_drain_arb.sv
// tb/tb_tsu_q_drain_arb.sv - directed self-checking bench for tsu_q_drain_arb

module tb_tsu_q_drain_arb;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- DUT with RD_LAT=1 ----------------
  logic         en = 1'b0;
  logic         out_ready = 1'b0;
  int           rx_wr = 0, tx_wr = 0;   // pushes, driven by the stimulus
  int           rx_rd = 0, tx_rd = 0;   // pops, driven by the queue model
  logic [7:0]   rx_q_stat, tx_q_stat;
  logic [127:0] rx_q_data, tx_q_data;
  logic         rx_q_rd_en, tx_q_rd_en;
  logic         out_valid, out_src, busy;
  logic [127:0] out_data;

  assign rx_q_stat = 8'(rx_wr - rx_rd);
  assign tx_q_stat = 8'(tx_wr - tx_rd);

`ifdef TSU_Q_DRAIN_CNT_EN
  logic        cnt_clr = 1'b0;
  logic [15:0] rx_cnt, tx_cnt;
  logic        cnt_clr3 = 1'b0;
  logic [15:0] rx_cnt3, tx_cnt3;
`endif

  tsu_q_drain_arb #(.RD_LAT(1), .STAT_W(8), .DATA_W(128)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .rx_q_stat  (rx_q_stat),
    .rx_q_data  (rx_q_data),
    .rx_q_rd_en (rx_q_rd_en),
    .tx_q_stat  (tx_q_stat),
    .tx_q_data  (tx_q_data),
    .tx_q_rd_en (tx_q_rd_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_src    (out_src),
    .busy       (busy)
`ifdef TSU_Q_DRAIN_CNT_EN
    ,
    .cnt_clr    (cnt_clr),
    .rx_cnt     (rx_cnt),
    .tx_cnt     (tx_cnt)
`endif
  );

  // ---------------- DUT with RD_LAT=3 (RX only) ----------------
  logic         en3 = 1'b1;
  logic         ready3 = 1'b1;
  int           rx3_wr = 0, rx3_rd = 0;
  logic [7:0]   rx3_stat;
  logic [7:0]   tx3_stat = 8'd0;
  logic [127:0] tx3_data = '0;
  logic [127:0] p3_0, p3_1, p3_2;
  logic         rx3_rd_en, tx3_rd_en, out3_valid, out3_src, busy3;
  logic [127:0] out3_data;

  assign rx3_stat = 8'(rx3_wr - rx3_rd);

  tsu_q_drain_arb #(.RD_LAT(3), .STAT_W(8), .DATA_W(128)) u_dut3 (
    .clk        (clk),
    .rst        (rst),
    .en         (en3),
    .rx_q_stat  (rx3_stat),
    .rx_q_data  (p3_2),
    .rx_q_rd_en (rx3_rd_en),
    .tx_q_stat  (tx3_stat),
    .tx_q_data  (tx3_data),
    .tx_q_rd_en (tx3_rd_en),
    .out_valid  (out3_valid),
    .out_ready  (ready3),
    .out_data   (out3_data),
    .out_src    (out3_src),
    .busy       (busy3)
`ifdef TSU_Q_DRAIN_CNT_EN
    ,
    .cnt_clr    (cnt_clr3),
    .rx_cnt     (rx_cnt3),
    .tx_cnt     (tx_cnt3)
`endif
  );

  function automatic logic [127:0] rx_word(input int i);
    return {4{32'h5258_0000 + 32'(i)}};
  endfunction

  function automatic logic [127:0] tx_word(input int i);
    return {4{32'h5458_0000 + 32'(i)}};
  endfunction

  // ---------------- queue models ----------------
  int   cyc = 0;
  int   rd_total = 0;
  int   rd_cyc [0:255];
  logic rd_src [0:255];
  int   viol = 0;
  int   rd3_n = 0, rd3_first = 0, rd3_last = 0;

  // Data appears one cycle after the strobe and is X otherwise.
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    rx_q_data <= 'x;
    tx_q_data <= 'x;
    if (rx_q_rd_en) begin
      rx_q_data <= rx_word(rx_rd);
      rx_rd     <= rx_rd + 1;
    end
    if (tx_q_rd_en) begin
      tx_q_data <= tx_word(tx_rd);
      tx_rd     <= tx_rd + 1;
    end
    if (rx_q_rd_en || tx_q_rd_en) begin
      rd_cyc[rd_total[7:0]] <= cyc;
      rd_src[rd_total[7:0]] <= tx_q_rd_en;
      rd_total              <= rd_total + 1;
    end
    if ((rx_q_rd_en && tx_q_rd_en) || (rx_q_rd_en && rx_q_stat == 8'd0) ||
        (tx_q_rd_en && tx_q_stat == 8'd0) || tx3_rd_en ||
        (rx3_rd_en && rx3_stat == 8'd0))
      viol <= viol + 1;
  end

  // Three-stage read pipeline: X until the third cycle after the strobe.
  always @(posedge clk) begin
    p3_0 <= rx3_rd_en ? rx_word(100 + rx3_rd) : 'x;
    p3_1 <= p3_0;
    p3_2 <= p3_1;
    if (rx3_rd_en) begin
      rx3_rd <= rx3_rd + 1;
      if (rd3_n == 0) rd3_first <= cyc;
      rd3_last <= cyc;
      rd3_n    <= rd3_n + 1;
    end
  end

  // Waits (bounded) for the RD_LAT=1 DUT to present an entry.
  task automatic get_out(output logic got, output logic [127:0] d, output logic s,
                         output int vcyc);
    got = 1'b0; d = '0; s = 1'b0; vcyc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1; d = out_data; s = out_src; vcyc = cyc;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if ({rx_q_rd_en, tx_q_rd_en} !== 2'b00) begin errors++; $display("FAIL reset_rd_en got=%b exp=00", {rx_q_rd_en, tx_q_rd_en}); end
    checks++; if (out_data !== 128'd0 || out_src !== 1'b0) begin errors++; $display("FAIL reset_data got=%h/%b exp=0/0", out_data, out_src); end
    rst = 1'b1;
    en = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_both;
    logic got, s, exps; logic [127:0] d, expd; int vc, rb, tb0, nr, nt, base;
    rb = rx_rd; tb0 = tx_rd; nr = 0; nt = 0; base = rd_total;
    rx_wr += 2; tx_wr += 2;
    for (int k = 0; k < 4; k++) begin
      get_out(got, d, s, vc);
      exps = k[0];
      expd = exps ? tx_word(tb0 + nt) : rx_word(rb + nr);
      if (exps) nt++; else nr++;
      checks++; if (!got) begin errors++; $display("FAIL both_timeout k=%0d got=none exp=entry", k); end
      checks++; if (s !== exps) begin errors++; $display("FAIL both_src k=%0d got=%b exp=%b", k, s, exps); end
      checks++; if (d !== expd) begin errors++; $display("FAIL both_data k=%0d got=%h exp=%h", k, d, expd); end
    end
    repeat (3) @(negedge clk);
    checks++; if (rd_src[base] !== 1'b0 || rd_src[base+1] !== 1'b1 || rd_src[base+2] !== 1'b0 || rd_src[base+3] !== 1'b1)
      begin errors++; $display("FAIL both_rd_order got=%b%b%b%b exp=0101", rd_src[base], rd_src[base+1], rd_src[base+2], rd_src[base+3]); end
  endtask

  task automatic test_rx_only;
    logic got, s; logic [127:0] d; int vc, v0, rb, base;
    rb = rx_rd; base = rd_total; v0 = 0;
    rx_wr += 3;
    for (int k = 0; k < 3; k++) begin
      get_out(got, d, s, vc);
      if (k == 0) v0 = vc;
      checks++; if (!got) begin errors++; $display("FAIL rx_only_timeout k=%0d got=none exp=entry", k); end
      checks++; if (s !== 1'b0) begin errors++; $display("FAIL rx_only_src k=%0d got=%b exp=0", k, s); end
      checks++; if (d !== rx_word(rb + k)) begin errors++; $display("FAIL rx_only_data k=%0d got=%h exp=%h", k, d, rx_word(rb + k)); end
    end
    repeat (4) @(negedge clk);
    checks++; if (rd_total - base != 3) begin errors++; $display("FAIL rx_only_reads got=%0d exp=3", rd_total - base); end
    checks++; if (rd_cyc[base+1] - rd_cyc[base] != 4) begin errors++; $display("FAIL rx_only_gap1 got=%0d exp=4", rd_cyc[base+1] - rd_cyc[base]); end
    checks++; if (rd_cyc[base+2] - rd_cyc[base+1] != 4) begin errors++; $display("FAIL rx_only_gap2 got=%0d exp=4", rd_cyc[base+2] - rd_cyc[base+1]); end
    // strobe cycle k, capture on the edge ending k+1, valid visible in k+2
    checks++; if (v0 - rd_cyc[base] != 2) begin errors++; $display("FAIL rx_only_latency got=%0d exp=2", v0 - rd_cyc[base]); end
  endtask

  task automatic test_stall;
    logic got, s, stable; logic [127:0] d, d2; int vc, rb, snap;
    out_ready = 1'b0;
    rb = rx_rd;
    rx_wr += 2;
    get_out(got, d, s, vc);
    checks++; if (!got || d !== rx_word(rb)) begin errors++; $display("FAIL stall_first got=%h exp=%h", d, rx_word(rb)); end
    snap = rd_total; stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== d || out_src !== 1'b0 || rx_q_rd_en || tx_q_rd_en) stable = 1'b0;
    end
    checks++; if (!stable) begin errors++; $display("FAIL stall_hold got=unstable exp=stable"); end
    checks++; if (rd_total != snap) begin errors++; $display("FAIL stall_no_reads got=%0d exp=%0d", rd_total, snap); end
    out_ready = 1'b1;
    get_out(got, d2, s, vc);
    checks++; if (!got || d2 !== rx_word(rb + 1)) begin errors++; $display("FAIL stall_next got=%h exp=%h", d2, rx_word(rb + 1)); end
    checks++; if (rd_total != snap + 1) begin errors++; $display("FAIL stall_resume_reads got=%0d exp=%0d", rd_total, snap + 1); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_en_drop;
    logic got, s, seen, ok; logic [127:0] d; int vc, rb, snap;
    rb = rx_rd; seen = 1'b0;
    rx_wr += 6;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rx_q_rd_en) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL en_drop_rd got=none exp=strobe"); end
    @(negedge clk);
    en = 1'b0;
    get_out(got, d, s, vc);
    checks++; if (!got || d !== rx_word(rb)) begin errors++; $display("FAIL en_drop_entry got=%h exp=%h", d, rx_word(rb)); end
    snap = rd_total;
    repeat (8) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_drop_busy got=%b exp=0", busy); end
    checks++; if (rx_q_stat !== 8'd5) begin errors++; $display("FAIL en_drop_stat got=%0d exp=5", rx_q_stat); end
    checks++; if (rd_total != snap) begin errors++; $display("FAIL en_drop_no_reads got=%0d exp=%0d", rd_total, snap); end
    en = 1'b1;
    ok = 1'b1;
    for (int k = 1; k < 6; k++) begin
      get_out(got, d, s, vc);
      if (!got || d !== rx_word(rb + k) || s !== 1'b0) ok = 1'b0;
    end
    checks++; if (!ok) begin errors++; $display("FAIL en_drop_resume got=bad exp=5 rx entries"); end
    repeat (3) @(negedge clk);
    checks++; if (rx_q_stat !== 8'd0) begin errors++; $display("FAIL en_drop_drained got=%0d exp=0", rx_q_stat); end
  endtask

  task automatic test_lat3;
    logic got; logic [127:0] d; int vc;
    rx3_wr += 2;
    got = 1'b0; d = '0; vc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out3_valid) begin got = 1'b1; d = out3_data; vc = cyc; break; end
    end
    checks++; if (!got) begin errors++; $display("FAIL lat3_timeout got=none exp=entry"); end
    checks++; if (^d === 1'bx) begin errors++; $display("FAIL lat3_x got=%h exp=known", d); end
    checks++; if (d !== rx_word(100)) begin errors++; $display("FAIL lat3_data got=%h exp=%h", d, rx_word(100)); end
    checks++; if (out3_src !== 1'b0) begin errors++; $display("FAIL lat3_src got=%b exp=0", out3_src); end
    // capture edge is 3 edges after the strobe edge; visible one cycle later
    checks++; if (vc - rd3_first != 4) begin errors++; $display("FAIL lat3_latency got=%0d exp=4", vc - rd3_first); end
    got = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out3_valid) begin got = 1'b1; d = out3_data; break; end
    end
    checks++; if (!got || d !== rx_word(101)) begin errors++; $display("FAIL lat3_second got=%h exp=%h", d, rx_word(101)); end
    checks++; if (rd3_n != 2 || rd3_last - rd3_first != 6) begin errors++; $display("FAIL lat3_period got=%0d/%0d exp=2/6", rd3_n, rd3_last - rd3_first); end
    repeat (3) @(negedge clk);
    checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL lat3_idle got=%b exp=0", busy3); end
  endtask

  task automatic test_reset_hold;
    logic got, s; logic [127:0] d; int vc, rb2, tb2;
    out_ready = 1'b0;
    rx_wr += 1;
    get_out(got, d, s, vc);
    checks++; if (!got || s !== 1'b0) begin errors++; $display("FAIL rst_hold_setup got=%b/%b exp=1/0", got, s); end
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_hold_async got=%b/%b exp=0/0", out_valid, busy); end
    // the held entry was already popped, so it is lost
    rx_wr += 1; tx_wr += 1;
    rb2 = rx_rd; tb2 = tx_rd;
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
`ifdef TSU_Q_DRAIN_CNT_EN
    checks++; if (rx_cnt !== 16'd0 || tx_cnt !== 16'd0) begin errors++; $display("FAIL cnt_reset got=%0d/%0d exp=0/0", rx_cnt, tx_cnt); end
    cnt_clr = 1'b1;
`endif
    get_out(got, d, s, vc);
    checks++; if (!got || s !== 1'b0) begin errors++; $display("FAIL rst_hold_rx_first got=%b exp=0", s); end
    checks++; if (d !== rx_word(rb2)) begin errors++; $display("FAIL rst_hold_data got=%h exp=%h", d, rx_word(rb2)); end
    @(negedge clk);
`ifdef TSU_Q_DRAIN_CNT_EN
    cnt_clr = 1'b0;
    checks++; if (rx_cnt !== 16'd0) begin errors++; $display("FAIL cnt_clr_wins got=%0d exp=0", rx_cnt); end
`endif
    get_out(got, d, s, vc);
    checks++; if (!got || s !== 1'b1 || d !== tx_word(tb2)) begin errors++; $display("FAIL rst_hold_tx got=%b/%h exp=1/%h", s, d, tx_word(tb2)); end
    @(negedge clk);
`ifdef TSU_Q_DRAIN_CNT_EN
    checks++; if (tx_cnt !== 16'd1 || rx_cnt !== 16'd0) begin errors++; $display("FAIL cnt_tx_inc got=%0d/%0d exp=1/0", tx_cnt, rx_cnt); end
`endif
  endtask

  task automatic test_protocol;
    checks++; if (viol != 0) begin errors++; $display("FAIL protocol_violations got=%0d exp=0", viol); end
  endtask

  initial begin
    test_reset();
    test_both();
    test_rx_only();
    test_stall();
    test_en_drop();
    test_lat3();
    test_reset_hold();
    test_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
